// File: rtl/load_store_unit_if.sv
// Datapath/memory-side signal bundle for load_store_unit.
// slave = the LSU itself; master = datapath plus data memory.
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        fault;
  logic        busy;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req, we, size, sign, addr, wdata, mem_rd,
    output rdata, ack, fault, busy, mem_we, mem_a, mem_wd
  );

  modport master (
    output req, we, size, sign, addr, wdata, mem_rd,
    input  rdata, ack, fault, busy, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit over a word-indexed memory, with RMW for sub-word stores.
// LSU_ALIGN_CHECK_EN: reject misaligned/out-of-range accesses instead of force-aligning/wrapping.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RMW, S_WR, S_ERR, S_ACK
  } state_t;

  state_t      state_q, state_d;
  logic        sign_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [29:0] widx_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;

  logic [1:0]  acc_size;
  logic [1:0]  acc_off;
  logic [29:0] acc_idx;
  logic        acc_fault;
  logic        accept;

  assign accept = (state_q == S_IDLE) && bus.req;

`ifdef LSU_ALIGN_CHECK_EN
  always_comb begin
    acc_size  = bus.size;
    acc_off   = bus.addr[1:0];
    acc_idx   = bus.addr[31:2];
    acc_fault = (bus.size == 2'b11)
             || ((bus.size == 2'b01) && bus.addr[0])
             || ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00))
             || ({2'b00, bus.addr[31:2]} >= MEM_WORDS);
  end
`else
  localparam logic [29:0] IDX_MOD = 30'(MEM_WORDS);

  // Illegal size degrades to word; offsets are forced to the access's natural alignment.
  always_comb begin
    acc_size  = (bus.size == 2'b11) ? 2'b10 : bus.size;
    acc_off   = 2'b00;
    case (acc_size)
      2'b00:   acc_off = bus.addr[1:0];
      2'b01:   acc_off = {bus.addr[1], 1'b0};
      default: acc_off = 2'b00;
    endcase
    acc_idx   = bus.addr[31:2] % IDX_MOD;
    acc_fault = 1'b0;
  end
`endif

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  always_comb begin
    rd_byte  = bus.mem_rd[{off_q, 3'b000} +: 8];
    rd_half  = off_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
    load_val = bus.mem_rd;
    case (size_q)
      2'b00:   load_val = {{24{sign_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{sign_q & rd_half[15]}}, rd_half};
      default: load_val = bus.mem_rd;
    endcase
    merge_val = bus.mem_rd;
    if (size_q == 2'b00) merge_val[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merge_val[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          if (acc_fault)              state_d = S_ERR;
          else if (!bus.we)           state_d = S_RD;
          else if (acc_size == 2'b10) state_d = S_WR;
          else                        state_d = S_RMW;
        end
      end
      S_RD:    state_d = S_ACK;
      S_RMW:   state_d = S_WR;
      S_WR:    state_d = S_ACK;
      S_ERR:   state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory strobes decode straight from state so reset kills mem_we without waiting for an edge.
  always_comb begin
    bus.busy   = (state_q != S_IDLE);
    bus.ack    = (state_q == S_ACK);
    bus.mem_we = (state_q == S_WR);
    bus.mem_a  = '0;
    bus.mem_wd = '0;
    if ((state_q == S_RD) || (state_q == S_RMW) || (state_q == S_WR))
      bus.mem_a = {2'b00, widx_q};
    if (state_q == S_WR)
      bus.mem_wd = (size_q == 2'b10) ? wdata_q : merge_q;
    bus.rdata  = rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sign_q  <= bus.sign;
        size_q  <= acc_size;
        off_q   <= acc_off;
        widx_q  <= acc_idx;
        wdata_q <= bus.wdata;
      end
      if (state_q == S_RD)  rdata_q <= load_val;
      if (state_q == S_RMW) merge_q <= merge_val;
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 fault_q <= 1'b0;
    else if (accept)           fault_q <= 1'b0;
    else if (state_q == S_ERR) fault_q <= 1'b1;
  end

  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

endmodule
